// File: rtl/rv_pkg.sv
// Decode-stage types shared by the decoder, the decode controller and the bench.
//   opcode_e   : RV32I base opcodes this stage recognises
//   alu_op_e   : ALU / M-extension operation select
//   IMM_*/WB_*/A_* : immediate format, writeback source, ALU operand A source
//   dec_ctrl_t : one decoded instruction as handed to EX
//   alu_fn     : funct3 (+ alternate bit) -> base ALU op
package rv_pkg;
  localparam int PC_W = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLT = 5'd2,  ALU_SLTU = 5'd3,
    ALU_XOR = 5'd4,  ALU_OR  = 5'd5,  ALU_AND = 5'd6,  ALU_SLL  = 5'd7,
    ALU_SRL = 5'd8,  ALU_SRA = 5'd9,
    ALU_MUL = 5'd10, ALU_MULH = 5'd11, ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13,
    ALU_DIV = 5'd14, ALU_DIVU = 5'd15, ALU_REM = 5'd16, ALU_REMU = 5'd17
  } alu_op_e;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
  localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;

  typedef struct packed {
    alu_op_e         alu_op;
    logic            reg_wen;
    logic [1:0]      alu_a_sel;
    logic            alu_b_sel;   // 1: immediate, 0: rs2
    logic [2:0]      imm_sel;
    logic [1:0]      wb_sel;
    logic            dmem_we;
    logic            is_branch;
    logic            is_jump;
    logic [2:0]      br_type;
    logic            br_un;
    logic            lsu_signed;
    logic [1:0]      lsu_size;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [PC_W-1:0] pc;
    logic            insn_vld;
  } dec_ctrl_t;

  function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_fn = ALU_SLL;
      3'd2:    alu_fn = ALU_SLT;
      3'd3:    alu_fn = ALU_SLTU;
      3'd4:    alu_fn = ALU_XOR;
      3'd5:    alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/inst_decode_comb.sv
// Combinational RV32I(+M) decoder.
//   inst : instruction word
//   pc   : PC of inst, copied into the decoded entry
//   dec  : decoded control; all-zero (insn_vld=0) for illegal encodings
// Register specifiers are filled in only for registers the instruction really
// reads/writes, so a hazard compare on rs1/rs2 never fires on immediate bits.
module inst_decode_comb
  import rv_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  output dec_ctrl_t       dec
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  dec_ctrl_t  d;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  always_comb begin
    d     = '0;
    legal = 1'b1;
    case (inst[6:0])
      OPC_LUI: begin
        d.reg_wen = 1'b1; d.alu_a_sel = A_ZERO; d.alu_b_sel = 1'b1;
        d.imm_sel = IMM_U; d.wb_sel = WB_ALU; d.rd = inst[11:7];
      end
      OPC_AUIPC: begin
        d.reg_wen = 1'b1; d.alu_a_sel = A_PC; d.alu_b_sel = 1'b1;
        d.imm_sel = IMM_U; d.wb_sel = WB_ALU; d.rd = inst[11:7];
      end
      OPC_JAL: begin
        d.reg_wen = 1'b1; d.alu_a_sel = A_PC; d.alu_b_sel = 1'b1;
        d.imm_sel = IMM_J; d.wb_sel = WB_PC4; d.is_jump = 1'b1; d.rd = inst[11:7];
      end
      OPC_JALR: begin
        d.reg_wen = 1'b1; d.alu_a_sel = A_RS1; d.alu_b_sel = 1'b1;
        d.imm_sel = IMM_I; d.wb_sel = WB_PC4; d.is_jump = 1'b1;
        d.rs1 = inst[19:15]; d.rd = inst[11:7];
      end
      OPC_BRANCH: begin
        // ALU forms the target (PC+imm); EX does the compare from br_type/br_un.
        d.alu_a_sel = A_PC; d.alu_b_sel = 1'b1; d.imm_sel = IMM_B;
        d.is_branch = 1'b1; d.br_type = f3; d.br_un = f3[1];
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
      end
      OPC_LOAD: begin
        d.reg_wen = 1'b1; d.alu_b_sel = 1'b1; d.imm_sel = IMM_I; d.wb_sel = WB_MEM;
        d.lsu_signed = ~f3[2]; d.lsu_size = f3[1:0];
        d.rs1 = inst[19:15]; d.rd = inst[11:7];
      end
      OPC_STORE: begin
        d.dmem_we = 1'b1; d.alu_b_sel = 1'b1; d.imm_sel = IMM_S; d.lsu_size = f3[1:0];
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
      end
      OPC_IMM: begin
        d.reg_wen = 1'b1; d.alu_b_sel = 1'b1; d.imm_sel = IMM_I; d.wb_sel = WB_ALU;
        d.alu_op = alu_fn(f3, (f3 == 3'd5) & inst[30]);
        d.rs1 = inst[19:15]; d.rd = inst[11:7];
      end
      OPC_OP: begin
        d.reg_wen = 1'b1; d.wb_sel = WB_ALU;
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.rd = inst[11:7];
        if (f7 == 7'h01) begin
          if (EN_MEXT) d.alu_op = alu_op_e'(5'd10 + {2'b00, f3});
          else         legal = 1'b0;
        end else if (f7 == 7'h00) begin
          d.alu_op = alu_fn(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          d.alu_op = alu_fn(f3, 1'b1);
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      d.insn_vld = 1'b1;
      d.pc       = pc;
    end else begin
      d = '0;
    end
  end

  assign dec = d;
endmodule

// File: rtl/pipe_decode_ctrl.sv
// Decode stage between IF and EX: decodes the offered instruction, stalls it on a
// load-use hazard, and queues the result in a small in-order output FIFO.
//   i_clk/i_reset            : clock, async active-low reset
//   i_inst_vld/o_inst_rdy    : IF handshake, i_inst/i_pc the offered instruction
//   i_flush                  : redirect, drops queued and incoming instructions
//   i_ex_load/i_ex_rd        : load currently in EX and its destination
//   o_dec_vld/i_dec_rdy/o_dec: EX handshake on the FIFO head
module pipe_decode_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter bit EN_MEXT   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_inst_vld,
  output logic            o_inst_rdy,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rd,
  output logic            o_dec_vld,
  input  logic            i_dec_rdy,
  output dec_ctrl_t       o_dec
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

  dec_ctrl_t        dec_in;
  dec_ctrl_t        mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, cnt_nxt;
  occ_e             occ;
  logic             hazard, push, pop;

  inst_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
    .inst(i_inst),
    .pc  (PC_W'(i_pc)),
    .dec (dec_in)
  );

  // Decoder zeroes unused specifiers, so only real register reads can match.
  assign hazard = i_ex_load & (i_ex_rd != 5'd0) &
                  ((i_ex_rd == dec_in.rs1) | (i_ex_rd == dec_in.rs2));

  assign o_dec_vld  = (occ != EMPTY);
  assign pop        = o_dec_vld & i_dec_rdy;
  // Full FIFO still accepts when the head leaves the same cycle.
  assign o_inst_rdy = ((occ != FULL) | pop) & ~hazard & ~i_flush;
  assign push       = i_inst_vld & o_inst_rdy;
  assign o_dec      = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (push & ~pop)      cnt_nxt = count + 1'b1;
    else if (pop & ~push) cnt_nxt = count - 1'b1;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= EMPTY;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= cnt_nxt;
      if (cnt_nxt == '0)                       occ <= EMPTY;
      else if (cnt_nxt == CNT_W'(BUF_DEPTH))   occ <= FULL;
      else                                     occ <= PARTIAL;
    end
  end
endmodule
